// File: rtl/mtimer.sv
// mtimer: machine timer peripheral (mtime / mtimecmp / mtip).
// Register map by addr[3:2]: 0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi.
// Optional build macro MTIMER_SNAPSHOT_EN: a read of mtime lo latches the high word
// into a shadow that later mtime hi reads return, giving a tear-free 64-bit read.
module mtimer #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TICK_DIV   = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strobe,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic [63:0]           time_o,
    output logic                  mtip
);

    localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    // Byte-lane merge of a write word into an existing register word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strobe);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[i*8 +: 8] = strobe[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return result;
    endfunction

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic [63:0]      mtime_r;
    logic [63:0]      mtime_nxt_s;
    logic [63:0]      mtimecmp_r;
    logic [63:0]      mtimecmp_nxt_s;
    logic [31:0]      rd_data_r;
    logic [31:0]      rd_mux_s;
    logic             rd_valid_r;
    logic             mtip_r;
    logic             wr_s;
    logic             rd_s;
    logic [1:0]       sel_s;
    logic             wr_mtime_s;
    logic             unused_addr_s;

    assign wr_s          = req & we;
    assign rd_s          = req & ~we;
    assign sel_s         = addr[3:2];
    assign wr_mtime_s    = wr_s & (sel_s[1] == 1'b0);
    assign tick_s        = (pre_r == PRE_MAX);
    assign unused_addr_s = ^addr[1:0];

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] shadow_r;

    // Shadow of the high word: latched on lo reads, refreshed by any mtime write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= 32'd0;
        end else if (wr_mtime_s) begin
            shadow_r <= mtime_nxt_s[63:32];
        end else if (rd_s && (sel_s == 2'd0)) begin
            shadow_r <= mtime_r[63:32];
        end else begin
            shadow_r <= shadow_r;
        end
    end
`endif

    // Prescaler: counts 0..TICK_DIV-1, wrapping in the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            pre_r <= {PRE_W{1'b0}};
        end else begin
            pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Next mtime: a write to either half wins and suppresses the whole increment.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_s && (sel_s == 2'd0)) begin
            mtime_nxt_s[31:0] = merge_bytes(mtime_r[31:0], wr_data, wr_strobe);
        end else if (wr_s && (sel_s == 2'd1)) begin
            mtime_nxt_s[63:32] = merge_bytes(mtime_r[63:32], wr_data, wr_strobe);
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Next mtimecmp: byte-enabled writes to either half.
    always_comb begin
        mtimecmp_nxt_s = mtimecmp_r;
        if (wr_s && (sel_s == 2'd2)) begin
            mtimecmp_nxt_s[31:0] = merge_bytes(mtimecmp_r[31:0], wr_data, wr_strobe);
        end else if (wr_s && (sel_s == 2'd3)) begin
            mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], wr_data, wr_strobe);
        end else begin
            mtimecmp_nxt_s = mtimecmp_r;
        end
    end

    // Read mux over pre-edge register values.
    always_comb begin
        rd_mux_s = 32'd0;
        case (sel_s)
            2'd0:    rd_mux_s = mtime_r[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            2'd1:    rd_mux_s = shadow_r;
`else
            2'd1:    rd_mux_s = mtime_r[63:32];
`endif
            2'd2:    rd_mux_s = mtimecmp_r[31:0];
            2'd3:    rd_mux_s = mtimecmp_r[63:32];
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_r    <= 64'd0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
        end
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= 32'd0;
            rd_valid_r <= 1'b0;
        end else if (rd_s) begin
            rd_data_r  <= rd_mux_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= 1'b0;
        end
    end

    // Interrupt pending: registered unsigned compare of current register values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtip_r <= 1'b0;
        end else begin
            mtip_r <= (mtime_r >= mtimecmp_r);
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign mtip     = mtip_r;
    assign time_o   = mtime_r;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer (TICK_DIV=4) against a cycle-count based reference model.
module tb_mtimer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [63:0] time_o;
    logic        mtip;

    int vec = 0;
    int err = 0;

    // Reference model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [31:0] m_rd;
    logic        m_rdv;
    logic        m_mtip;
    int          m_cyc;

    always #5 clk = ~clk;

    mtimer #(.ADDR_WIDTH(4), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
        .rd_valid(rd_valid), .time_o(time_o), .mtip(mtip)
    );

    function automatic logic [31:0] blend(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_reset();
        m_time = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 32'd0;
        m_rd = 32'd0; m_rdv = 1'b0; m_mtip = 1'b0; m_cyc = 0;
    endtask

    // One clock cycle with the given bus access; advances the model by one cycle.
    task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        logic        tick;
        logic [63:0] nt;
        logic [63:0] nc;
        logic [31:0] rv;
        req = r; we = w; addr = a; wr_data = d; wr_strobe = s;
        tick = ((m_cyc % TD) == (TD - 1));
        nt = m_time;
        nc = m_cmp;
        if (r && w) begin
            case (a[3:2])
                2'd0: nt[31:0]  = blend(m_time[31:0], d, s);
                2'd1: nt[63:32] = blend(m_time[63:32], d, s);
                2'd2: nc[31:0]  = blend(m_cmp[31:0], d, s);
                default: nc[63:32] = blend(m_cmp[63:32], d, s);
            endcase
        end
        if (!(r && w && (a[3] == 1'b0)) && tick) nt = m_time + 64'd1;
        case (a[3:2])
            2'd0: rv = m_time[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            2'd1: rv = m_shadow;
`else
            2'd1: rv = m_time[63:32];
`endif
            2'd2: rv = m_cmp[31:0];
            default: rv = m_cmp[63:32];
        endcase
        @(posedge clk);
        #1;
        m_mtip = (m_time >= m_cmp);
        if (r && !w) begin
            m_rd = rv; m_rdv = 1'b1;
        end else begin
            m_rdv = 1'b0;
        end
`ifdef MTIMER_SNAPSHOT_EN
        if (r && w && (a[3] == 1'b0)) m_shadow = nt[63:32];
        else if (r && !w && (a[3:2] == 2'd0)) m_shadow = m_time[63:32];
`endif
        m_time = nt;
        m_cmp = nc;
        m_cyc++;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'd0, 4'h0);
    endtask

    // Idle until the next cycle's position in the prescaler period is k.
    task automatic align(input int k);
        for (int i = 0; i < TD && (m_cyc % TD) != k; i++) idle(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 4'h0; wr_data = 32'd0; wr_strobe = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (time_o !== 64'd0) begin err++; $display("FAIL reset_time: got %h want 0", time_o); end
        vec++; if (mtip !== 1'b0) begin err++; $display("FAIL reset_mtip: got %b want 0", mtip); end
        vec++; if (rd_valid !== 1'b0) begin err++; $display("FAIL reset_rdv: got %b want 0", rd_valid); end
        vec++; if (rd_data !== 32'd0) begin err++; $display("FAIL reset_rdd: got %h want 0", rd_data); end
        cycle(1'b1, 1'b0, 4'h8, 32'd0, 4'h0);
        vec++; if (rd_data !== 32'hFFFF_FFFF || rd_valid !== 1'b1) begin err++; $display("FAIL reset_cmp_lo: got %h/%b want ffffffff/1", rd_data, rd_valid); end
        cycle(1'b1, 1'b0, 4'hC, 32'd0, 4'h0);
        vec++; if (rd_data !== 32'hFFFF_FFFF) begin err++; $display("FAIL reset_cmp_hi: got %h want ffffffff", rd_data); end
    endtask

    task automatic test_count();
        do_reset();
        idle(40);
        vec++; if (time_o !== 64'd10) begin err++; $display("FAIL count_time: got %h want a", time_o); end
        vec++; if (mtip !== 1'b0) begin err++; $display("FAIL count_mtip: got %b want 0", mtip); end
        cycle(1'b1, 1'b0, 4'h0, 32'd0, 4'h0);
        vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h0000_000A) begin err++; $display("FAIL count_read: got %h/%b want 0000000a/1", rd_data, rd_valid); end
        idle(1);
        vec++; if (rd_valid !== 1'b0 || rd_data !== 32'h0000_000A) begin err++; $display("FAIL count_hold: got %h/%b want 0000000a/0", rd_data, rd_valid); end
    endtask

    task automatic test_carry();
        align(0);
        cycle(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF);
        cycle(1'b1, 1'b1, 4'h4, 32'h0, 4'hF);
        vec++; if (time_o !== 64'h0000_0000_FFFF_FFFF) begin err++; $display("FAIL carry_pre: got %h want ffffffff", time_o); end
        idle(2);
        vec++; if (time_o !== 64'h0000_0001_0000_0000) begin err++; $display("FAIL carry_post: got %h want 100000000", time_o); end
    endtask

    task automatic test_mtip();
        int i;
        cycle(1'b1, 1'b1, 4'h4, 32'h0, 4'hF);
        cycle(1'b1, 1'b1, 4'hC, 32'h0, 4'hF);
        cycle(1'b1, 1'b1, 4'h8, 32'h20, 4'hF);
        cycle(1'b1, 1'b1, 4'h0, 32'h1F, 4'hF);
        vec++; if (mtip !== 1'b0 || time_o !== 64'h1F) begin err++; $display("FAIL mtip_setup: got %b/%h want 0/1f", mtip, time_o); end
        for (i = 0; i < 20 && time_o !== 64'h20; i++) idle(1);
        vec++; if (time_o !== 64'h20) begin err++; $display("FAIL mtip_timeout: got %h want 20", time_o); end
        vec++; if (mtip !== 1'b0) begin err++; $display("FAIL mtip_latency0: got %b want 0", mtip); end
        idle(1);
        vec++; if (mtip !== 1'b1) begin err++; $display("FAIL mtip_rise: got %b want 1", mtip); end
        cycle(1'b1, 1'b1, 4'h8, 32'h100, 4'hF);
        vec++; if (mtip !== m_mtip) begin err++; $display("FAIL mtip_wr_edge: got %b want %b", mtip, m_mtip); end
        idle(1);
        vec++; if (mtip !== 1'b0) begin err++; $display("FAIL mtip_clear: got %b want 0", mtip); end
    endtask

    task automatic test_strobe_tick();
        align(2);
        cycle(1'b1, 1'b1, 4'h0, 32'h7, 4'hF);
        cycle(1'b1, 1'b1, 4'h8, 32'h0000_0055, 4'b0001);
        vec++; if (time_o !== 64'd8) begin err++; $display("FAIL strobe_tick_time: got %h want 8", time_o); end
        align(3);
        cycle(1'b1, 1'b1, 4'h0, 32'h3, 4'hF);
        vec++; if (time_o !== 64'd3) begin err++; $display("FAIL wr_tick_suppress: got %h want 3", time_o); end
        cycle(1'b1, 1'b0, 4'h8, 32'd0, 4'h0);
        vec++; if (rd_data !== 32'h0000_0155) begin err++; $display("FAIL strobe_cmp_lo: got %h want 00000155", rd_data); end
        cycle(1'b1, 1'b0, 4'hC, 32'd0, 4'h0);
        vec++; if (rd_data !== 32'h0) begin err++; $display("FAIL strobe_cmp_hi: got %h want 0", rd_data); end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b1, 4'h8, 32'h0, 4'hF);
        align(0);
        cycle(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF);
        vec++; if (mtip !== 1'b1) begin err++; $display("FAIL wrap_mtip_a: got %b want 1", mtip); end
        cycle(1'b1, 1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF);
        vec++; if (time_o !== 64'hFFFF_FFFF_FFFF_FFFF || mtip !== 1'b1) begin err++; $display("FAIL wrap_pre: got %h/%b want ffffffffffffffff/1", time_o, mtip); end
        idle(2);
        vec++; if (time_o !== 64'd0 || mtip !== 1'b1) begin err++; $display("FAIL wrap_post: got %h/%b want 0/1", time_o, mtip); end
        idle(1);
        vec++; if (mtip !== 1'b1) begin err++; $display("FAIL wrap_mtip_after: got %b want 1", mtip); end
    endtask

    task automatic test_snapshot();
        align(0);
        cycle(1'b1, 1'b1, 4'h4, 32'h0, 4'hF);
        cycle(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF);
        cycle(1'b1, 1'b0, 4'h0, 32'd0, 4'h0);
        vec++; if (rd_data !== 32'hFFFF_FFFF) begin err++; $display("FAIL snap_lo: got %h want ffffffff", rd_data); end
        idle(1);
        vec++; if (time_o !== 64'h0000_0001_0000_0000) begin err++; $display("FAIL snap_tick: got %h want 100000000", time_o); end
        cycle(1'b1, 1'b0, 4'h4, 32'd0, 4'h0);
`ifdef MTIMER_SNAPSHOT_EN
        vec++; if (rd_data !== 32'h0) begin err++; $display("FAIL snap_hi: got %h want 0", rd_data); end
`else
        vec++; if (rd_data !== 32'h1) begin err++; $display("FAIL snap_hi: got %h want 1", rd_data); end
`endif
    endtask

    task automatic test_reset_mid_access();
        cycle(1'b1, 1'b0, 4'h0, 32'd0, 4'h0);
        req = 1'b1; we = 1'b0; addr = 4'h0;
        #3;
        rst_n = 1'b0;
        #1;
        vec++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin err++; $display("FAIL midrst_rd: got %h/%b want 0/0", rd_data, rd_valid); end
        vec++; if (time_o !== 64'd0 || mtip !== 1'b0) begin err++; $display("FAIL midrst_state: got %h/%b want 0/0", time_o, mtip); end
        we = 1'b1; addr = 4'h8; wr_data = 32'h0; wr_strobe = 4'hF;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 4'h8, 32'd0, 4'h0);
        vec++; if (rd_data !== 32'hFFFF_FFFF) begin err++; $display("FAIL midrst_nowrite: got %h want ffffffff", rd_data); end
    endtask

    task automatic test_random();
        logic        r;
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom % 2) == 0;
            w = ($urandom % 4) == 0;
            a = 4'($urandom % 16);
            d = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom);
            cycle(r, w, a, d, 4'($urandom % 16));
            vec++; if (time_o !== m_time) begin err++; $display("FAIL rand_time[%0d]: got %h want %h", i, time_o, m_time); end
            vec++; if (mtip !== m_mtip) begin err++; $display("FAIL rand_mtip[%0d]: got %b want %b", i, mtip, m_mtip); end
            vec++; if (rd_valid !== m_rdv) begin err++; $display("FAIL rand_rdv[%0d]: got %b want %b", i, rd_valid, m_rdv); end
            vec++; if (rd_data !== m_rd) begin err++; $display("FAIL rand_rdd[%0d]: got %h want %h", i, rd_data, m_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_mtip();
        test_strobe_tick();
        test_wrap();
        test_snapshot();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
